// File: rtl/regfile_seq_pkg.sv
// Shared constants for the register-file sequencer: opcodes, FSM encoding and
// instruction field positions.
package regfile_seq_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_MOV = 3'b101;
    localparam logic [OP_W-1:0] OP_LDI = 3'b110;
    localparam logic [OP_W-1:0] OP_NOP = 3'b111;

    // Field slot index; bit position of a field is slot * ADDR_W.
    localparam int unsigned FIELD_RS2 = 0;
    localparam int unsigned FIELD_RS1 = 1;
    localparam int unsigned FIELD_RD  = 2;
    localparam int unsigned FIELD_OP  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/alu8.sv
// Combinational ALU for the sequencer. carry_valid is low for NOP so the
// caller can leave its result and flag registers untouched.
module alu8
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry_out,
    output logic              o_carry_valid
);

    logic [DATA_W:0] w_wide;

    // Top bit of the widened subtraction is the borrow (set when a < b).
    always_comb begin
        w_wide        = '0;
        o_carry_valid = 1'b1;
        case (i_op)
            OP_ADD:  w_wide = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB:  w_wide = {1'b0, i_a} - {1'b0, i_b};
            OP_AND:  w_wide = {1'b0, i_a & i_b};
            OP_OR:   w_wide = {1'b0, i_a | i_b};
            OP_XOR:  w_wide = {1'b0, i_a ^ i_b};
            OP_MOV:  w_wide = {1'b0, i_a};
            OP_LDI:  w_wide = {1'b0, i_imm};
            default: o_carry_valid = 1'b0;
        endcase
    end

    assign o_result    = w_wide[DATA_W-1:0];
    assign o_carry_out = w_wide[DATA_W];

endmodule

// File: rtl/regfile_sequencer.sv
// Four-state controller that reads two registers, runs the ALU and writes the
// result back, one instruction per valid/ready handshake.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [3+3*ADDR_W-1:0] instr,
    input  logic [DATA_W-1:0]     imm,
    output logic [ADDR_W-1:0]     read_port_1,
    output logic [ADDR_W-1:0]     read_port_2,
    input  logic [DATA_W-1:0]     read_data_1,
    input  logic [DATA_W-1:0]     read_data_2,
    output logic [ADDR_W-1:0]     write_port_1,
    output logic                  write_enable,
    output logic [DATA_W-1:0]     write_data,
    output logic                  done,
    output logic                  carry,
    output logic                  zero
);

    state_e              r_state;
    state_e              w_state_next;
    logic [OP_W-1:0]     r_op;
    logic [ADDR_W-1:0]   r_rd;
    logic [ADDR_W-1:0]   r_rs1;
    logic [ADDR_W-1:0]   r_rs2;
    logic [ADDR_W-1:0]   r_wport;
    logic [DATA_W-1:0]   r_imm;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_carry;
    logic                r_zero;
    logic [DATA_W-1:0]   w_result;
    logic                w_carry;
    logic                w_carry_valid;

    alu8 #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op          (r_op),
        .i_a           (r_a),
        .i_b           (r_b),
        .i_imm         (r_imm),
        .o_result      (w_result),
        .o_carry_out   (w_carry),
        .o_carry_valid (w_carry_valid)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (instr_valid) w_state_next = READ;
            READ:    w_state_next = EXEC;
            EXEC:    w_state_next = WRITE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= OP_NOP;
            r_rd    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_wport <= '0;
            r_imm   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_wdata <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && instr_valid) begin
                r_op  <= instr[FIELD_OP*ADDR_W +: OP_W];
                r_rd  <= instr[FIELD_RD*ADDR_W +: ADDR_W];
                r_rs1 <= instr[FIELD_RS1*ADDR_W +: ADDR_W];
                r_rs2 <= instr[FIELD_RS2*ADDR_W +: ADDR_W];
                r_imm <= imm;
            end
            // Operands are captured a cycle before the write, so rd == rs uses the old value.
            if (r_state == READ) begin
                r_a <= read_data_1;
                r_b <= read_data_2;
            end
            if (r_state == EXEC) begin
                r_wport <= r_rd;
                if (w_carry_valid) begin
                    r_wdata <= w_result;
                    r_carry <= w_carry;
                    r_zero  <= (w_result == '0);
                end
            end
        end
    end

    assign instr_ready  = (r_state == IDLE);
    assign read_port_1  = r_rs1;
    assign read_port_2  = r_rs2;
    assign write_port_1 = r_wport;
    assign write_data   = r_wdata;
    assign write_enable = (r_state == WRITE) && (r_op != OP_NOP);
    assign done         = (r_state == WRITE);
    assign carry        = r_carry;
    assign zero         = r_zero;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer with a behavioural 8x8 register file alongside.
module tb_regfile_sequencer;
    import regfile_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [11:0] instr;
    logic [7:0]  imm;
    logic [2:0]  read_port_1;
    logic [2:0]  read_port_2;
    logic [7:0]  read_data_1;
    logic [7:0]  read_data_2;
    logic [2:0]  write_port_1;
    logic        write_enable;
    logic [7:0]  write_data;
    logic        done;
    logic        carry;
    logic        zero;

    always #5 clk = ~clk;

    regfile_sequencer #(
        .DATA_W (8),
        .ADDR_W (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .imm          (imm),
        .read_port_1  (read_port_1),
        .read_port_2  (read_port_2),
        .read_data_1  (read_data_1),
        .read_data_2  (read_data_2),
        .write_port_1 (write_port_1),
        .write_enable (write_enable),
        .write_data   (write_data),
        .done         (done),
        .carry        (carry),
        .zero         (zero)
    );

    logic [7:0] rf [8];
    logic       rf_init;

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (write_enable) begin
            rf[write_port_1] <= write_data;
        end
    end

    assign read_data_1 = rf[read_port_1];
    assign read_data_2 = rf[read_port_2];

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    int done_count = 0;

    always @(negedge clk) begin
        if (!rst && write_enable) we_count <= we_count + 1;
        if (!rst && done) done_count <= done_count + 1;
    end

    typedef struct {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [7:0] imm;
        logic [7:0] wd;
        logic       c;
        logic       z;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(logic [2:0] op, logic [2:0] rd, logic [2:0] rs1,
                                logic [2:0] rs2, logic [7:0] im, logic [7:0] wd,
                                logic c, logic z);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = im;
        v.wd = wd; v.c = c; v.z = z;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the READ cycle.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [7:0] im);
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("ready_timeout", 0, 1);
        instr       = {op, rd, rs1, rs2};
        imm         = im;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        issue(v.op, v.rd, v.rs1, v.rs2, v.imm);
        @(negedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_done", idx), done, 1);
        chk($sformatf("v%0d_we", idx), write_enable, (v.op != OP_NOP) ? 1 : 0);
        if (v.op != OP_NOP) chk($sformatf("v%0d_wport", idx), write_port_1, v.rd);
        chk($sformatf("v%0d_wdata", idx), write_data, v.wd);
        chk($sformatf("v%0d_carry", idx), carry, v.c);
        chk($sformatf("v%0d_zero", idx), zero, v.z);
        @(negedge clk);
        chk($sformatf("v%0d_ready", idx), instr_ready, 1);
        chk($sformatf("v%0d_done_off", idx), done, 0);
    endtask

    logic [7:0]  exp_rf [8];
    logic [11:0] b2b_instr [3];
    logic [7:0]  b2b_imm [3];

    initial begin
        rst         = 1'b1;
        rf_init     = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        imm         = '0;

        vecs[0]  = mk(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h0F, 8'h0F, 1'b0, 1'b0);
        vecs[1]  = mk(OP_LDI, 3'd2, 3'd0, 3'd0, 8'hF1, 8'hF1, 1'b0, 1'b0);
        vecs[2]  = mk(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00, 8'h00, 1'b1, 1'b1);
        vecs[3]  = mk(OP_LDI, 3'd4, 3'd0, 3'd0, 8'h05, 8'h05, 1'b0, 1'b0);
        vecs[4]  = mk(OP_LDI, 3'd5, 3'd0, 3'd0, 8'h07, 8'h07, 1'b0, 1'b0);
        vecs[5]  = mk(OP_SUB, 3'd6, 3'd4, 3'd5, 8'h00, 8'hFE, 1'b1, 1'b0);
        vecs[6]  = mk(OP_SUB, 3'd6, 3'd5, 3'd4, 8'h00, 8'h02, 1'b0, 1'b0);
        vecs[7]  = mk(OP_AND, 3'd7, 3'd1, 3'd2, 8'h00, 8'h01, 1'b0, 1'b0);
        vecs[8]  = mk(OP_OR,  3'd7, 3'd1, 3'd2, 8'h00, 8'hFF, 1'b0, 1'b0);
        vecs[9]  = mk(OP_XOR, 3'd7, 3'd1, 3'd2, 8'h00, 8'hFE, 1'b0, 1'b0);
        vecs[10] = mk(OP_MOV, 3'd0, 3'd2, 3'd0, 8'h00, 8'hF1, 1'b0, 1'b0);
        vecs[11] = mk(OP_LDI, 3'd1, 3'd0, 3'd0, 8'hAA, 8'hAA, 1'b0, 1'b0);
        vecs[12] = mk(OP_ADD, 3'd1, 3'd1, 3'd1, 8'h00, 8'h54, 1'b1, 1'b0);
        // NOP targets r7 with a distinctive imm; nothing may change.
        vecs[13] = mk(OP_NOP, 3'd7, 3'd3, 3'd4, 8'h99, 8'h54, 1'b1, 1'b0);

        exp_rf = '{8'hF1, 8'h54, 8'hF1, 8'h00, 8'h05, 8'h07, 8'h02, 8'hFE};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", instr_ready, 1);
        chk("rst_we", write_enable, 0);
        chk("rst_done", done, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_flags", {carry, zero}, 0);
        chk("rst_ports", {read_port_1, read_port_2, write_port_1}, 0);
        rst     = 1'b0;
        rf_init = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        for (int i = 0; i < 8; i++) chk($sformatf("rf_r%0d", i), rf[i], exp_rf[i]);

        // instr_valid held high: accepts land every fourth edge.
        b2b_instr[0] = {OP_LDI, 3'd2, 3'd0, 3'd0}; b2b_imm[0] = 8'h11;
        b2b_instr[1] = {OP_LDI, 3'd3, 3'd0, 3'd0}; b2b_imm[1] = 8'h22;
        b2b_instr[2] = {OP_ADD, 3'd4, 3'd2, 3'd3}; b2b_imm[2] = 8'h00;
        begin
            int k = 0;
            int pulses = 0;
            for (int n = 0; n < 12; n++) begin
                chk($sformatf("b2b_ready_c%0d", n), instr_ready, (n % 4 == 0) ? 1 : 0);
                chk($sformatf("b2b_we_eq_done_c%0d", n), write_enable, done);
                if (write_enable) pulses++;
                if (instr_ready && k < 3) begin
                    instr       = b2b_instr[k];
                    imm         = b2b_imm[k];
                    instr_valid = 1'b1;
                    k++;
                end else if (k == 3) begin
                    instr_valid = 1'b0;
                end
                @(negedge clk);
            end
            instr_valid = 1'b0;
            chk("b2b_pulses", pulses, 3);
        end
        chk("b2b_r4", rf[4], 8'h33);
        chk("b2b_wdata", write_data, 8'h33);

        // Reset during EXEC of LDI r7,0x3C must drop the instruction.
        issue(OP_LDI, 3'd7, 3'd0, 3'd0, 8'h3C);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstx_we", write_enable, 0);
        chk("rstx_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstx_ready", instr_ready, 1);
        chk("rstx_we2", write_enable, 0);
        chk("rstx_done2", done, 0);
        chk("rstx_wdata", write_data, 0);
        chk("rstx_flags", {carry, zero}, 0);
        chk("rstx_ports", {read_port_1, read_port_2, write_port_1}, 0);
        repeat (3) @(negedge clk);
        chk("rstx_r7", rf[7], 8'hFE);
        chk("total_we", we_count, 16);
        chk("total_done", done_count, 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Initiator-side controller for the 8x8 two-read/one-write register file. It accepts one register-to-register instruction per valid/ready handshake and drives both read port addresses. It captures the returned operands, computes the result in an 8-bit ALU, and issues a single-cycle write back through the write port. It sits between an instruction source (testbench or future fetch unit) and the register file, and owns every register file control signal.

## Interface
- DATA_W, 8, datapath and register width
- ADDR_W, 3, register address width; instruction width is 3+3*ADDR_W
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- instr_valid  input  1  instruction offered
- instr_ready  output  1  sequencer can accept an instruction
- instr  input  3+3*ADDR_W  fields {op[11:9], rd[8:6], rs1[5:3], rs2[2:0]}
- imm  input  DATA_W  immediate for LDI, sampled with instr
- read_port_1  output  ADDR_W  rs1 address to register file
- read_port_2  output  ADDR_W  rs2 address to register file
- read_data_1  input  DATA_W  register file data for read_port_1, combinational
- read_data_2  input  DATA_W  register file data for read_port_2, combinational
- write_port_1  output  ADDR_W  destination address (rd)
- write_enable  output  1  register file write strobe
- write_data  output  DATA_W  write-back value
- done  output  1  one-cycle pulse when an instruction retires
- carry  output  1  carry/borrow flag
- zero  output  1  result-is-zero flag

## Operation
- Opcodes:
  - 000 ADD: rs1+rs2
  - 001 SUB: rs1-rs2
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 MOV: rs1
  - 110 LDI: imm
  - 111 NOP: no write
- FSM states: IDLE, READ, EXEC, WRITE. Transitions are unconditional except IDLE.
  - IDLE: instr_ready=1; on instr_valid, latch instr and imm, go to READ.
  - READ: read ports driven from the latched rs1/rs2; capture read_data_1/2 into operand registers; go to EXEC.
  - EXEC: ALU result registered into write_data; flags updated; go to WRITE.
  - WRITE: write_enable=1 unless op=NOP; done=1; go to IDLE.
- Arithmetic (all unsigned, result truncated to DATA_W):
  - ADD: carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - SUB: carry = borrow (1 when rs1<rs2).
  - AND/OR/XOR/MOV/LDI: carry=0.
  - zero = (result==0).
  - NOP: both flags unchanged.
- read_port_1/2, write_port_1 and write_data hold their last values outside their active state.
- write_enable and done are decoded from the state register only, never from inputs.
- rd may equal rs1 or rs2. Operands are captured before the write, so the old value is used.
- Reset values: state=IDLE, instr_ready=1, all address outputs 0, write_data=0, write_enable=0, done=0, carry=0, zero=0.
- Reset asserted in any state: return to IDLE next edge. No write is issued, and an in-flight instruction is discarded without done.

## Timing
- Handshake completes at edge E0 when instr_valid && instr_ready.
- E1: operands captured.
- E2: result and flags registered.
- Cycle E2–E3: write_enable and done high.
- E3: register file stores the result; state returns to IDLE.
- Throughput is one instruction per 4 cycles. instr_ready is low in READ/EXEC/WRITE.
- instr_valid held high continuously: instructions are accepted at E0, E4, E8, …
- Flags are visible from E2 and hold until the next non-NOP EXEC.

## Structure
- Package regfile_seq_pkg holds:
  - opcode localparams OP_ADD..OP_NOP
  - state encoding IDLE=2'd0, READ=2'd1, EXEC=2'd2, WRITE=2'd3
  - instruction field bit positions
- Sub-module alu8 (combinational):
  - inputs op, a, b, imm
  - outputs result, carry_out, carry_valid
  - instantiated once in regfile_sequencer
- The register file module is instantiated alongside in the bench, not inside this block.

## Test plan
- LDI r1,0x0F; LDI r2,0xF1; ADD r3,r1,r2 → write_port_1=3, write_data=0x00, carry=1, zero=1. r3 then reads back 0x00.
- LDI r4,0x05; LDI r5,0x07; SUB r6,r4,r5 → write_data=0xFE, carry=1, zero=0. SUB r6,r5,r4 → 0x02, carry=0.
- instr_valid held high for 3 instructions → instr_ready pulses at E0/E4/E8; exactly three write_enable pulses, each coincident with done.
- LDI r1,0xAA, then ADD r1,r1,r1 (rd=rs1=rs2) → write_data=0x54, carry=1; r1 reads 0x54 afterward.
- NOP after an ADD with carry=1 → done pulses, write_enable stays 0, carry and zero unchanged, register file contents unchanged.
- rst asserted during EXEC of LDI r7,0x3C → no write_enable, no done, r7 unchanged, instr_ready=1 one cycle after rst deasserts, all outputs at reset values.
